// File: rtl/mem_to_bmb.sv
// mem_to_bmb: bridges mem req/gnt single-word accesses to single-beat BMB commands, one outstanding; MEM_TO_BMB_TIMEOUT_EN adds a response timeout
module mem_to_bmb #(
   parameter int AddrSize      = 32,
   parameter int DataSize      = 64,
   parameter int PayloadBits   = 2,
   parameter int TimeoutCycles = 255
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    mem_req,
   output logic                    mem_gnt,
   input  logic [AddrSize-1:0]     mem_addr,
   input  logic [DataSize-1:0]     mem_wdata,
   input  logic [DataSize/8-1:0]   mem_strb,
   input  logic                    mem_we,
   output logic                    mem_rvalid,
   output logic [DataSize-1:0]     mem_rdata,
   output logic                    mem_err,
   output logic                    bmb_cmd_valid,
   input  logic                    bmb_cmd_ready,
   output logic [AddrSize-1:0]     bmb_cmd_payload_address,
   output logic [PayloadBits-1:0]  bmb_cmd_payload_size,
   output logic                    bmb_cmd_payload_wr,
   output logic                    bmb_cmd_payload_uncached,
   output logic [DataSize-1:0]     bmb_cmd_payload_data,
   output logic [DataSize/8-1:0]   bmb_cmd_payload_mask,
   output logic                    bmb_cmd_payload_last,
   input  logic                    bmb_rsp_valid,
   output logic                    bmb_rsp_ready,
   input  logic [DataSize-1:0]     bmb_rsp_payload_data,
   input  logic                    bmb_rsp_payload_last,
   input  logic                    bmb_rsp_payload_error,
   output logic                    unexpected_rsp_o
);
   localparam int StrbSize = DataSize / 8;
   localparam int LowBits  = $clog2(StrbSize);
   typedef enum logic [1:0] {IDLE, CMD, RSP} state_t;
   state_t                state;
   logic [AddrSize-1:0]   addr_q;
   logic [DataSize-1:0]   wdata_q;
   logic [StrbSize-1:0]   strb_q;
   logic                  we_q;
   logic [DataSize-1:0]   rdata_q;
   logic                  err_q;
   logic                  rvalid_q;
   logic                  unexp_q;
   logic                  first_q;
   logic                  timeout;
`ifdef MEM_TO_BMB_TIMEOUT_EN
   localparam int TimerRaw  = $clog2(TimeoutCycles + 1);
   localparam int TimerBits = TimerRaw < 8 ? 8 : (TimerRaw > 32 ? 32 : TimerRaw);
   logic [TimerBits-1:0] timer_q;
   assign timeout = timer_q == TimerBits'(TimeoutCycles);
   always_ff @(posedge clk_i)
      if (rst_i || state == CMD) timer_q <= '0;
      else if (state == RSP && !bmb_rsp_valid) timer_q <= timer_q + 1'b1;
`else
   assign timeout = 1'b0;
`endif
   assign mem_gnt                  = state == IDLE && !rst_i;
   assign mem_rvalid               = rvalid_q;
   assign mem_rdata                = rdata_q;
   assign mem_err                  = err_q;
   assign bmb_cmd_valid            = state == CMD;
   assign bmb_cmd_payload_address  = addr_q & ~AddrSize'(StrbSize - 1);
   assign bmb_cmd_payload_size     = PayloadBits'(LowBits);
   assign bmb_cmd_payload_wr       = we_q;
   assign bmb_cmd_payload_uncached = 1'b1;
   assign bmb_cmd_payload_data     = wdata_q;
   assign bmb_cmd_payload_mask     = strb_q;
   assign bmb_cmd_payload_last     = 1'b1;
   assign bmb_rsp_ready            = 1'b1;
   assign unexpected_rsp_o         = unexp_q;
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state    <= IDLE;
         addr_q   <= '0;
         wdata_q  <= '0;
         strb_q   <= '0;
         we_q     <= 1'b0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
         rvalid_q <= 1'b0;
         unexp_q  <= 1'b0;
         first_q  <= 1'b0;
      end else begin
         rvalid_q <= 1'b0;
         if (bmb_rsp_valid && state != RSP) unexp_q <= 1'b1;
         case (state)
            IDLE: if (mem_req) begin
               addr_q  <= mem_addr;
               wdata_q <= mem_wdata;
               strb_q  <= mem_strb;
               we_q    <= mem_we;
               state   <= CMD;
            end
            CMD: if (bmb_cmd_ready) begin
               first_q <= 1'b1;
               state   <= RSP;
            end
            RSP: if (bmb_rsp_valid) begin
               rdata_q <= first_q ? bmb_rsp_payload_data : rdata_q;
               err_q   <= bmb_rsp_payload_error | (!first_q && err_q);
               first_q <= 1'b0;
               if (bmb_rsp_payload_last) begin
                  state    <= IDLE;
                  rvalid_q <= 1'b1;
               end
            end else if (timeout) begin
               rdata_q  <= '0;
               err_q    <= 1'b1;
               rvalid_q <= 1'b1;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_to_bmb.sv
// tb_mem_to_bmb: randomized scoreboard bench for mem_to_bmb with a queue-based response model
module tb_mem_to_bmb;
   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        mem_req = 1'b0;
   logic        mem_gnt;
   logic [31:0] mem_addr = '0;
   logic [63:0] mem_wdata = '0;
   logic [7:0]  mem_strb = '0;
   logic        mem_we = 1'b0;
   logic        mem_rvalid;
   logic [63:0] mem_rdata;
   logic        mem_err;
   logic        bmb_cmd_valid;
   logic        bmb_cmd_ready = 1'b0;
   logic [31:0] bmb_cmd_payload_address;
   logic [1:0]  bmb_cmd_payload_size;
   logic        bmb_cmd_payload_wr;
   logic        bmb_cmd_payload_uncached;
   logic [63:0] bmb_cmd_payload_data;
   logic [7:0]  bmb_cmd_payload_mask;
   logic        bmb_cmd_payload_last;
   logic        bmb_rsp_valid = 1'b0;
   logic        bmb_rsp_ready;
   logic [63:0] bmb_rsp_payload_data = '0;
   logic        bmb_rsp_payload_last = 1'b0;
   logic        bmb_rsp_payload_error = 1'b0;
   logic        unexpected_rsp_o;
   int          checks = 0;
   int          failures = 0;
   int          rv_cnt = 0;
   logic [64:0] exp_q[$];
   always #5 clk_i = ~clk_i;
   mem_to_bmb #(.TimeoutCycles(8)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_strb(mem_strb), .mem_we(mem_we), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .mem_err(mem_err), .bmb_cmd_valid(bmb_cmd_valid), .bmb_cmd_ready(bmb_cmd_ready),
      .bmb_cmd_payload_address(bmb_cmd_payload_address), .bmb_cmd_payload_size(bmb_cmd_payload_size),
      .bmb_cmd_payload_wr(bmb_cmd_payload_wr), .bmb_cmd_payload_uncached(bmb_cmd_payload_uncached),
      .bmb_cmd_payload_data(bmb_cmd_payload_data), .bmb_cmd_payload_mask(bmb_cmd_payload_mask),
      .bmb_cmd_payload_last(bmb_cmd_payload_last), .bmb_rsp_valid(bmb_rsp_valid),
      .bmb_rsp_ready(bmb_rsp_ready), .bmb_rsp_payload_data(bmb_rsp_payload_data),
      .bmb_rsp_payload_last(bmb_rsp_payload_last), .bmb_rsp_payload_error(bmb_rsp_payload_error),
      .unexpected_rsp_o(unexpected_rsp_o)
   );
   task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", n, act, exp);
      end
   endtask
   always @(negedge clk_i) begin
      if (mem_rvalid) begin
         logic [64:0] e;
         rv_cnt++;
         if (exp_q.size() == 0) chk("spurious_rvalid", 64'd1, 64'd0);
         else begin
            e = exp_q.pop_front();
            chk("rdata", mem_rdata, e[63:0]);
            chk("err", {63'd0, mem_err}, {63'd0, e[64]});
         end
      end
   end
   task automatic cyc;
      @(posedge clk_i);
      #1;
   endtask
   task automatic issue(input logic [31:0] a, input logic [63:0] wd, input logic [7:0] st, input logic we, input int dly);
      mem_req = 1'b1; mem_addr = a; mem_wdata = wd; mem_strb = st; mem_we = we;
      @(negedge clk_i);
      chk("gnt_idle", mem_gnt, 1);
      cyc();
      mem_req = 1'b0; mem_addr = $urandom; mem_wdata = {$urandom, $urandom};
      mem_strb = 8'($urandom); mem_we = 1'($urandom);
      for (int i = 0; i <= dly; i++) begin
         bmb_cmd_ready = (i == dly);
         @(negedge clk_i);
         chk("cmd_valid", bmb_cmd_valid, 1);
         chk("cmd_addr", bmb_cmd_payload_address, a & 32'hFFFF_FFF8);
         chk("cmd_size", bmb_cmd_payload_size, 3);
         chk("cmd_wr", bmb_cmd_payload_wr, we);
         chk("cmd_uncached", bmb_cmd_payload_uncached, 1);
         chk("cmd_last", bmb_cmd_payload_last, 1);
         chk("cmd_data", bmb_cmd_payload_data, wd);
         chk("cmd_mask", bmb_cmd_payload_mask, st);
         chk("gnt_cmd", mem_gnt, 0);
         cyc();
      end
      bmb_cmd_ready = 1'b0;
   endtask
   task automatic respond(input int n, input logic [63:0] d [3], input logic [2:0] e, input int gmax);
      logic er = 1'b0;
      for (int j = 0; j < n; j++) er |= e[j];
      exp_q.push_back({er, d[0]});
      for (int j = 0; j < n; j++) begin
         repeat ($urandom_range(gmax, 0)) begin
            @(negedge clk_i);
            chk("gnt_gap", mem_gnt, 0);
            cyc();
         end
         bmb_rsp_valid = 1'b1; bmb_rsp_payload_data = d[j];
         bmb_rsp_payload_error = e[j]; bmb_rsp_payload_last = (j == n - 1);
         @(negedge clk_i);
         chk("gnt_rsp", mem_gnt, 0);
         chk("rvalid_early", mem_rvalid, 0);
         cyc();
      end
      bmb_rsp_valid = 1'b0; bmb_rsp_payload_last = 1'b0; bmb_rsp_payload_error = 1'b0;
      bmb_rsp_payload_data = {$urandom, $urandom};
      @(negedge clk_i);
      chk("rvalid_latency", mem_rvalid, 1);
      chk("gnt_with_rvalid", mem_gnt, 1);
      cyc();
   endtask
   task automatic stray_beat;
      bmb_rsp_valid = 1'b1; bmb_rsp_payload_last = 1'b1; bmb_rsp_payload_data = {$urandom, $urandom};
      cyc();
      bmb_rsp_valid = 1'b0; bmb_rsp_payload_last = 1'b0;
      @(negedge clk_i);
      chk("unexpected_set", unexpected_rsp_o, 1);
      cyc();
   endtask
   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end
   initial begin
      logic [63:0] d [3];
      int rv0;
      mem_req = 1'b1;
      repeat (3) begin
         @(negedge clk_i);
         chk("rst_gnt", mem_gnt, 0);
         chk("rst_cmd_valid", bmb_cmd_valid, 0);
         chk("rst_rvalid", mem_rvalid, 0);
         chk("rst_unexp", unexpected_rsp_o, 0);
         chk("rst_rdata", mem_rdata, 0);
         chk("rst_addr", bmb_cmd_payload_address, 0);
      end
      mem_req = 1'b0;
      cyc();
      rst_i = 1'b0;
      cyc();
      d = '{64'h1122_3344_5566_7788, 64'd0, 64'd0};
      issue(32'h8000_0010, {$urandom, $urandom}, 8'hFF, 1'b0, 0);
      respond(1, d, 3'b000, 0);
      d = '{64'hA5A5_0000_FFFF_1234, 64'd0, 64'd0};
      issue(32'h8000_000C, 64'hDEAD_BEEF_CAFE_F00D, 8'hF0, 1'b1, 4);
      respond(1, d, 3'b000, 0);
      d = '{64'h0101_0202_0303_0404, 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222};
      issue(32'h0000_1000, {$urandom, $urandom}, 8'h0F, 1'b0, 1);
      respond(3, d, 3'b010, 0);
      chk("unexp_clean", unexpected_rsp_o, 0);
      for (int t = 0; t < 40; t++) begin
         logic [2:0] e;
         int n;
         n = $urandom_range(3, 1);
         for (int j = 0; j < 3; j++) begin
            d[j] = {$urandom, $urandom};
            e[j] = ($urandom_range(3, 0) == 0);
         end
         issue($urandom, {$urandom, $urandom}, 8'($urandom), 1'($urandom), $urandom_range(3, 0));
         respond(n, d, e, $urandom_range(2, 0));
      end
      stray_beat();
      d = '{64'h7777_8888_9999_AAAA, 64'd0, 64'd0};
      issue(32'h4000_0020, {$urandom, $urandom}, 8'h3C, 1'b1, 0);
      respond(1, d, 3'b000, 0);
      @(negedge clk_i);
      chk("unexpected_sticky", unexpected_rsp_o, 1);
      cyc();
      mem_req = 1'b1; mem_addr = 32'h1234_5678;
      cyc();
      mem_req = 1'b0;
      @(negedge clk_i);
      chk("cmd_before_rst", bmb_cmd_valid, 1);
      cyc();
      rst_i = 1'b1;
      cyc();
      @(negedge clk_i);
      chk("cmd_drop_rst", bmb_cmd_valid, 0);
      chk("gnt_in_rst", mem_gnt, 0);
      cyc();
      rst_i = 1'b0;
      @(negedge clk_i);
      chk("gnt_after_rst", mem_gnt, 1);
      chk("unexp_cleared", unexpected_rsp_o, 0);
      cyc();
      stray_beat();
      rst_i = 1'b1;
      cyc();
      cyc();
      rst_i = 1'b0;
      cyc();
      issue(32'h8000_0100, {$urandom, $urandom}, 8'hFF, 1'b0, 0);
`ifdef MEM_TO_BMB_TIMEOUT_EN
      exp_q.push_back({1'b1, 64'd0});
      for (int i = 0; i < 9; i++) begin
         @(negedge clk_i);
         chk("timeout_early", mem_rvalid, 0);
         cyc();
      end
      @(negedge clk_i);
      chk("timeout_rvalid", mem_rvalid, 1);
      chk("timeout_gnt", mem_gnt, 1);
      cyc();
      chk("unexp_before_late", unexpected_rsp_o, 0);
      stray_beat();
`else
      rv0 = rv_cnt;
      repeat (1000) cyc();
      @(negedge clk_i);
      chk("no_timeout_rvalid", 64'(rv_cnt - rv0), 0);
      chk("no_timeout_gnt", mem_gnt, 0);
      cyc();
      rst_i = 1'b1;
      cyc();
      rst_i = 1'b0;
      cyc();
`endif
      chk("scoreboard_empty", 64'(exp_q.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
